// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, result-source and forwarding codes.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic stallf;
        logic stalld;
        logic flushd;
        logic stalle;
        logic flushe;
        logic stallm;
    } ctrl_t;

    // x0 is hardwired zero, so it never matches as a producer
    function automatic logic reg_hit(input logic [4:0] prod, input logic [4:0] cons);
        return (prod != 5'd0) && (prod == cons);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// E-stage operand forwarding select for one source register; M stage wins over W stage.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rd_addr_e,
    input  logic [4:0] wr_addrm,
    input  logic       regwr_sgnm,
    input  logic [4:0] wr_addrw,
    input  logic       regwr_sgnw,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (regwr_sgnm && reg_hit(wr_addrm, rd_addr_e)) begin
            fwd_sel = FWD_MEM;
        end else if (regwr_sgnw && reg_hit(wr_addrw, rd_addr_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline with a data-memory wait FSM and timeout.
// Define HAZARD_PERF_EN to add saturating stall/flush/memwait performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rd_addr1d,
    input  logic [4:0]       rd_addr2d,
    input  logic [4:0]       rd_addr1e,
    input  logic [4:0]       rd_addr2e,
    input  logic [4:0]       wr_addre,
    input  logic [1:0]       result_sgne,
    input  logic [4:0]       wr_addrm,
    input  logic             regwr_sgnm,
    input  logic             memreq_m,
    input  logic             dmem_ready,
    input  logic [4:0]       wr_addrw,
    input  logic             regwr_sgnw,
    input  logic             pcsrce,
    output logic             stallf,
    output logic             stalld,
    output logic             flushd,
    output logic             stalle,
    output logic             flushe,
    output logic             stallm,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_memwait
`endif
);

    localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_t             ctrl;
    ctrl_t             run_ctrl;
    logic              mem_err_c;
    logic              load_use;
    logic [1:0]        fwd_a_sel, fwd_b_sel;

    hazard_fwd_sel u_fwd_a (
        .rd_addr_e  (rd_addr1e),
        .wr_addrm   (wr_addrm),
        .regwr_sgnm (regwr_sgnm),
        .wr_addrw   (wr_addrw),
        .regwr_sgnw (regwr_sgnw),
        .fwd_sel    (fwd_a_sel)
    );

    hazard_fwd_sel u_fwd_b (
        .rd_addr_e  (rd_addr2e),
        .wr_addrm   (wr_addrm),
        .regwr_sgnm (regwr_sgnm),
        .wr_addrw   (wr_addrw),
        .regwr_sgnw (regwr_sgnw),
        .fwd_sel    (fwd_b_sel)
    );

    assign load_use = (result_sgne == RES_LOAD) &&
                      (reg_hit(wr_addre, rd_addr1d) || reg_hit(wr_addre, rd_addr2d));

    // Redirect / load-use controls, used whenever memory is not holding the pipe
    always_comb begin
        run_ctrl = '0;
        if (pcsrce) begin
            run_ctrl.flushd = 1'b1;
            run_ctrl.flushe = 1'b1;
        end else if (load_use) begin
            run_ctrl.stallf = 1'b1;
            run_ctrl.stalld = 1'b1;
            run_ctrl.flushe = 1'b1;
        end
    end

    always_comb begin
        ctrl       = '0;
        mem_err_c  = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (state_q == RUN) begin
            wait_cnt_d = '0;
            if (memreq_m && !dmem_ready) begin
                ctrl    = '{stallf: 1'b1, stalld: 1'b1, flushd: 1'b0,
                            stalle: 1'b1, flushe: 1'b0, stallm: 1'b1};
                state_d = MEM_WAIT;
            end else begin
                ctrl = run_ctrl;
            end
        end else begin
            // On release the pipe advances this cycle, so a pending redirect must act now
            if (dmem_ready) begin
                ctrl       = run_ctrl;
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
                ctrl       = run_ctrl;
                mem_err_c  = 1'b1;
                state_d    = RUN;
                wait_cnt_d = '0;
            end else begin
                ctrl       = '{stallf: 1'b1, stalld: 1'b1, flushd: 1'b0,
                               stalle: 1'b1, flushe: 1'b0, stallm: 1'b1};
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        if (rst) begin
            ctrl       = '0;
            mem_err_c  = 1'b0;
            state_d    = RUN;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stallf     = ctrl.stallf;
    assign stalld     = ctrl.stalld;
    assign flushd     = ctrl.flushd;
    assign stalle     = ctrl.stalle;
    assign flushe     = ctrl.flushe;
    assign stallm     = ctrl.stallm;
    assign mem_err    = mem_err_c;
    assign forward_ae = rst ? FWD_RF : fwd_a_sel;
    assign forward_be = rst ? FWD_RF : fwd_b_sel;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic [CNT_W-1:0] perf_memwait_q, perf_memwait_d;

    always_comb begin
        perf_stall_d   = perf_stall_q;
        perf_flush_d   = perf_flush_q;
        perf_memwait_d = perf_memwait_q;
        if (ctrl.stalld && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
        if (ctrl.flushe && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 1'b1;
        end
        if ((state_q == MEM_WAIT) && (perf_memwait_q != '1)) begin
            perf_memwait_d = perf_memwait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
            perf_memwait_q <= '0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4); a negedge monitor pops expectations.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rd_addr1d, rd_addr2d, rd_addr1e, rd_addr2e, wr_addre, wr_addrm, wr_addrw;
    logic [1:0] result_sgne;
    logic       regwr_sgnm, regwr_sgnw, memreq_m, dmem_ready, pcsrce;
    logic       stallf, stalld, flushd, stalle, flushe, stallm, mem_err;
    logic [1:0] forward_ae, forward_be;

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0] exp_q[$];
    string       nm_q[$];

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_FRZ  = 6'b110101;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_BR   = 6'b001010;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr1d   (rd_addr1d),
        .rd_addr2d   (rd_addr2d),
        .rd_addr1e   (rd_addr1e),
        .rd_addr2e   (rd_addr2e),
        .wr_addre    (wr_addre),
        .result_sgne (result_sgne),
        .wr_addrm    (wr_addrm),
        .regwr_sgnm  (regwr_sgnm),
        .memreq_m    (memreq_m),
        .dmem_ready  (dmem_ready),
        .wr_addrw    (wr_addrw),
        .regwr_sgnw  (regwr_sgnw),
        .pcsrce      (pcsrce),
        .stallf      (stallf),
        .stalld      (stalld),
        .flushd      (flushd),
        .stalle      (stalle),
        .flushe      (flushe),
        .stallm      (stallm),
        .forward_ae  (forward_ae),
        .forward_be  (forward_be),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ex(input logic [5:0] c, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic me);
        return {c, fa, fb, me};
    endfunction

    // Monitor: DUT presents a control vector every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [10:0] e;
            logic [10:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            a  = {stallf, stalld, flushd, stalle, flushe, stallm, forward_ae, forward_be, mem_err};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got sf,sd,fd,se,fe,sm,fa,fb,err=%b required %b", nm, a, e);
            end
        end
    end

    task automatic clr_in();
        rd_addr1d = 0; rd_addr2d = 0; rd_addr1e = 0; rd_addr2e = 0;
        wr_addre = 0; result_sgne = 2'b00; wr_addrm = 0; regwr_sgnm = 0;
        memreq_m = 0; dmem_ready = 0; wr_addrw = 0; regwr_sgnw = 0; pcsrce = 0;
    endtask

    task automatic cyc(input string nm, input logic [10:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        @(posedge clk);
        #1;

        // Reset forces everything low even with hazards present
        memreq_m = 1; pcsrce = 1; regwr_sgnm = 1; wr_addrm = 3; rd_addr1e = 3;
        cyc("reset", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        rst = 0; clr_in();
        cyc("idle", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Load x5 in E, D consumes x5 as rs2
        result_sgne = 2'b01; wr_addre = 5; rd_addr1d = 3; rd_addr2d = 5;
        cyc("load_use_rs2", ex(C_LU, 2'b00, 2'b00, 1'b0));
        result_sgne = 2'b00; wr_addre = 0; regwr_sgnm = 1; wr_addrm = 5;
        cyc("bubble_no_stall", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        regwr_sgnm = 0; wr_addrm = 0; regwr_sgnw = 1; wr_addrw = 5; rd_addr2e = 5; rd_addr1e = 3;
        cyc("load_fwd_wb", ex(C_NONE, 2'b00, 2'b01, 1'b0));

        // x0 never hazards or forwards
        clr_in();
        result_sgne = 2'b01; regwr_sgnm = 1; regwr_sgnw = 1;
        cyc("x0_no_hazard", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Forwarding priority
        clr_in();
        regwr_sgnm = 1; wr_addrm = 7; regwr_sgnw = 1; wr_addrw = 7; rd_addr1e = 7; rd_addr2e = 7;
        cyc("fwd_m_over_w", ex(C_NONE, 2'b10, 2'b10, 1'b0));
        regwr_sgnm = 0;
        cyc("fwd_w_only", ex(C_NONE, 2'b01, 2'b01, 1'b0));
        regwr_sgnm = 1; wr_addrw = 9; rd_addr2e = 9;
        cyc("fwd_mixed", ex(C_NONE, 2'b10, 2'b01, 1'b0));
        regwr_sgnm = 0; regwr_sgnw = 0;
        cyc("fwd_no_wen", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Redirect beats load-use; non-load producer does not stall
        clr_in();
        result_sgne = 2'b01; wr_addre = 5; rd_addr1d = 5; pcsrce = 1;
        cyc("branch_over_lu", ex(C_BR, 2'b00, 2'b00, 1'b0));
        pcsrce = 0; result_sgne = 2'b10;
        cyc("non_load_no_stall", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        result_sgne = 2'b01;
        cyc("load_use_rs1", ex(C_LU, 2'b00, 2'b00, 1'b0));

        // Memory wait released by dmem_ready; pcsrce held off until release
        clr_in();
        memreq_m = 1;
        cyc("mw_entry", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("mw_wait0", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        pcsrce = 1;
        cyc("mw_wait1_br", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("mw_wait2_br", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        dmem_ready = 1;
        cyc("mw_release_br", ex(C_BR, 2'b00, 2'b00, 1'b0));
        clr_in();
        cyc("mw_after", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Timeout: four wait cycles, err pulses on the last, freeze released
        memreq_m = 1;
        cyc("to_entry", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("to_wait0", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("to_wait1", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("to_wait2", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("to_expire", ex(C_NONE, 2'b00, 2'b00, 1'b1));
        memreq_m = 0;
        cyc("to_single_pulse", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        // Reset on the would-be timeout cycle: no err, back in RUN
        memreq_m = 1;
        cyc("rst_entry", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("rst_wait0", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("rst_wait1", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("rst_wait2", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        rst = 1;
        cyc("rst_abort", ex(C_NONE, 2'b00, 2'b00, 1'b0));
        rst = 0; memreq_m = 0; pcsrce = 1;
        cyc("rst_run_branch", ex(C_BR, 2'b00, 2'b00, 1'b0));

        // Fresh wait after reset must count from zero again
        pcsrce = 0; memreq_m = 1;
        cyc("re_entry", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("re_wait0", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("re_wait1", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("re_wait2", ex(C_FRZ, 2'b00, 2'b00, 1'b0));
        cyc("re_expire", ex(C_NONE, 2'b00, 2'b00, 1'b1));
        clr_in();
        cyc("re_idle", ex(C_NONE, 2'b00, 2'b00, 1'b0));

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
